// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data memory access controller (LSU + debug/loader).
// Define DMEM_ARB_RR_EN for round-robin ties instead of fixed priority.
package dmem_arbiter_pkg;
  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_LB  = 6'd16;
  localparam logic [5:0] ALU_LH  = 6'd17;
  localparam logic [5:0] ALU_LW  = 6'd18;
  localparam logic [5:0] ALU_LBU = 6'd19;
  localparam logic [5:0] ALU_LHU = 6'd20;
  localparam logic [5:0] ALU_SB  = 6'd21;
  localparam logic [5:0] ALU_SH  = 6'd22;
  localparam logic [5:0] ALU_SW  = 6'd23;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;
endpackage

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [5:0]  op0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic [5:0]  op1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [5:0]  mem_op,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;
  acc_t   lat_q;
  acc_t   sel;
  logic   port_q;
  logic   err_q;
  logic   ld_q;
  logic   wr_q;
  logic   rd_q;
  logic   gnt;
  logic   gnt_port;
  logic   tie_port;
  logic   sel_ok;
  logic   sel_st;

  function automatic logic op_ok(
    input logic [5:0] op,
    input logic [1:0] lo
  );
    logic ok;
    ok = 1'b0;
    unique case (op)
      ALU_LB, ALU_LBU, ALU_SB: ok = 1'b1;
      ALU_LH, ALU_LHU, ALU_SH: ok = (lo != 2'd3);
      ALU_LW, ALU_SW:          ok = (lo == 2'd0);
      default:                 ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic op_st(input logic [5:0] op);
    return (op == ALU_SB) || (op == ALU_SH) ||
           (op == ALU_SW);
  endfunction

  always_comb begin
    gnt      = 1'b0;
    gnt_port = 1'b0;
    if (state_q == IDLE) begin
      unique case ({req1, req0})
        2'b11: begin
          gnt      = 1'b1;
          gnt_port = tie_port;
        end
        2'b01: begin
          gnt      = 1'b1;
          gnt_port = 1'b0;
        end
        2'b10: begin
          gnt      = 1'b1;
          gnt_port = 1'b1;
        end
        default: gnt = 1'b0;
      endcase
    end
  end

  always_comb begin
    sel = '{op: op0, addr: addr0, wdata: wdata0};
    if (gnt_port)
      sel = '{op: op1, addr: addr1, wdata: wdata1};
    sel_ok = op_ok(sel.op, sel.addr[1:0]);
    sel_st = op_st(sel.op);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt) state_d = sel_ok ? ISSUE : DONE;
      ISSUE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered at grant so they sit exactly in ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      port_q  <= 1'b0;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      if (gnt) begin
        lat_q  <= sel;
        port_q <= gnt_port;
        err_q  <= !sel_ok;
        ld_q   <= sel_ok && !sel_st;
        wr_q   <= sel_ok && sel_st;
        rd_q   <= sel_ok && !sel_st;
      end
    end
  end

`ifdef DMEM_ARB_RR_EN
  logic last_q;

  always_ff @(posedge clk) begin
    if (rst)
      last_q <= 1'b1;
    else if (gnt)
      last_q <= gnt_port;
  end

  assign tie_port = ~last_q;
`else
  localparam int CW = (STARVE_LIMIT < 1) ? 1 :
                      $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q;

  always_ff @(posedge clk) begin
    if (rst)
      starve_q <= '0;
    else if (!req1 || (gnt && gnt_port))
      starve_q <= '0;
    else if (starve_q != LIM)
      starve_q <= starve_q + 1'b1;
  end

  assign tie_port = (starve_q == LIM);
`endif

  assign busy      = (state_q != IDLE);
  assign ack0      = (state_q == DONE) && !port_q;
  assign ack1      = (state_q == DONE) && port_q;
  assign rsp_err   = (state_q == DONE) && err_q;
  assign rsp_rdata = ((state_q == DONE) && ld_q) ?
                     mem_rdata : '0;
  assign mem_op    = lat_q.op;
  assign mem_addr  = lat_q.addr;
  assign mem_wdata = lat_q.wdata;
  assign mem_wr    = wr_q;
  assign mem_rd    = rd_q;

  strobe_excl: assert property (
    @(posedge clk) disable iff (rst) !(mem_wr && mem_rd));
  ack_excl: assert property (
    @(posedge clk) disable iff (rst) !(ack0 && ack1));

endmodule
